// File: rtl/image_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : image_reader_if
// Purpose  : Memory-map read bus plus pixel valid/ready stream for image_reader.
// Revision : 1.0
// ============================================================================
interface image_reader_if;
  logic [31:0] address;
  logic        wboolean;
  logic [31:0] rdata;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output address,
    output wboolean,
    input  rdata,
    output pixel,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  address,
    input  wboolean,
    output rdata,
    input  pixel,
    input  pixel_valid,
    output pixel_ready
  );
endinterface
`default_nettype wire

// File: rtl/image_reader.sv
`default_nettype none
// ============================================================================
// Module   : image_reader
// Purpose  : Reads NUM_WORDS words from BASE_ADDR and streams rdata[7:0] as pixels.
// Revision : 1.0
// ============================================================================
module image_reader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned NUM_WORDS = 57600
) (
  input  wire            clk,
  input  wire            rst,
  input  wire            start,
  output logic           busy,
  output logic           done,
  image_reader_if.master bus
);

  localparam int unsigned          c_IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_OUT     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [c_IDX_W-1:0] r_index;
  logic [7:0]         r_pixel;
  logic               w_active;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_pixel <= 8'h00;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE:    if (start) r_index <= '0;
        S_CAPTURE: r_pixel <= bus.rdata[7:0];
        S_OUT:     if (bus.pixel_ready && (r_index != c_LAST_IDX)) r_index <= r_index + 1'b1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_OUT;
      S_OUT: begin
        if (bus.pixel_ready) w_next = (r_index == c_LAST_IDX) ? S_DONE : S_ISSUE;
      end
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Address is held through OUT so a stalled consumer sees no bus activity change.
  assign w_active        = (r_state == S_ISSUE) || (r_state == S_CAPTURE) || (r_state == S_OUT);
  assign bus.address     = w_active ? (BASE_ADDR + 32'(r_index)) : 32'd0;
  assign bus.wboolean    = 1'b0;
  assign bus.pixel       = r_pixel;
  assign bus.pixel_valid = (r_state == S_OUT);
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_image_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_reader
// Purpose  : Directed frame-level checks of image_reader on two parameter sets.
// Revision : 1.0
// ============================================================================
module tb_image_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        ready_a = 1'b1, ready_b = 1'b1;
  logic        busy_a, done_a, busy_b, done_b;
  logic [23:0] hi_xor = 24'h0;
  logic        sel = 1'b0;
  logic        wb_seen = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  image_reader_if bus_a ();
  image_reader_if bus_b ();

  image_reader #(.BASE_ADDR(32'd0), .NUM_WORDS(300)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  image_reader #(.BASE_ADDR(32'd57602), .NUM_WORDS(100)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  assign bus_a.pixel_ready = ready_a;
  assign bus_b.pixel_ready = ready_b;

  // Synchronous RAM models: word i holds i (upper bits optionally scrambled on A).
  always @(posedge clk) begin
    bus_a.rdata <= bus_a.address ^ {hi_xor, 8'h00};
    bus_b.rdata <= bus_b.address - 32'd57602;
  end

  always @(negedge clk) begin
    if (bus_a.wboolean !== 1'b0 || bus_b.wboolean !== 1'b0) wb_seen <= 1'b1;
  end

  wire [31:0] m_addr  = sel ? bus_b.address     : bus_a.address;
  wire [7:0]  m_pixel = sel ? bus_b.pixel       : bus_a.pixel;
  wire        m_valid = sel ? bus_b.pixel_valid : bus_a.pixel_valid;
  wire        m_busy  = sel ? busy_b            : busy_a;
  wire        m_done  = sel ? done_b            : done_a;

  typedef struct {
    string       name;
    bit          use_b;
    logic [23:0] hi;
    int          stall_word;
    int          stall_cycles;
    int          pulse_word;
    int          probe_word;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [7:0]  exp_last_pix;
    logic [7:0]  exp_probe_pix;
  } frame_t;

  frame_t tab [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic set_ready(input logic v);
    if (sel) ready_b = v; else ready_a = v;
  endtask

  task automatic run_frame(input frame_t f);
    int          words = 0, dones = 0, ord_err = 0, stall_err = 0, cd = 0;
    bit          fin = 0, stalled = 0;
    logic [31:0] first = '1, last = '1, sa;
    logic [7:0]  probe = 8'hxx, last_pix = 8'hxx, sp;
    sel    = f.use_b;
    hi_xor = f.hi;
    set_ready(1'b1);
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) set_start(1'b1);
      end else begin
        set_start(1'b0);
      end
      if (m_done) begin
        dones++;
        fin = 1;
        if (m_addr !== 32'd0) ord_err++;
      end else if (m_busy && m_addr !== f.exp_first + 32'(words)) begin
        ord_err++;
      end
      if (m_valid && !stalled && words == f.stall_word) begin
        stalled = 1;
        set_ready(1'b0);
        sa = m_addr;
        sp = m_pixel;
        repeat (f.stall_cycles) begin
          @(negedge clk);
          if (!m_valid || m_addr !== sa || m_pixel !== sp) stall_err++;
        end
        set_ready(1'b1);
      end
      if (m_valid) begin
        if (m_pixel !== 8'(words)) ord_err++;
        if (words == 0) first = m_addr;
        if (words == f.probe_word) probe = m_pixel;
        last     = m_addr;
        last_pix = m_pixel;
        words++;
        if (words == f.pulse_word) cd = 2;
      end
      if (!fin) @(negedge clk);
    end
    check({f.name, "_done_seen"}, 32'(fin), 32'd1);
    check({f.name, "_words"}, 32'(words), 32'(f.exp_words));
    check({f.name, "_first_addr"}, first, f.exp_first);
    check({f.name, "_last_addr"}, last, f.exp_last);
    check({f.name, "_last_pixel"}, 32'(last_pix), 32'(f.exp_last_pix));
    check({f.name, "_probe_pixel"}, 32'(probe), 32'(f.exp_probe_pix));
    check({f.name, "_order_errors"}, 32'(ord_err), 32'd0);
    check({f.name, "_stall_errors"}, 32'(stall_err), 32'd0);
    @(negedge clk);
    if (m_done) dones++;
    check({f.name, "_done_pulses"}, 32'(dones), 32'd1);
    check({f.name, "_busy_after"}, 32'(m_busy), 32'd0);
    hi_xor = 24'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    //        name        b  hi          stall   pulse probe words first          last           lastpix probepix
    tab[0] = '{"plain_a", 0, 24'h0,      -1, 0,  -1,  255, 300, 32'd0,         32'd299,       8'h2B,  8'hFF};
    tab[1] = '{"mask_a",  0, 24'hDEADBE, -1, 0,  -1,  165, 300, 32'd0,         32'd299,       8'h2B,  8'hA5};
    tab[2] = '{"stall_a", 0, 24'h0,       7, 10, -1,  256, 300, 32'd0,         32'd299,       8'h2B,  8'h00};
    tab[3] = '{"start_a", 0, 24'h0,      -1, 0,   5,    6, 300, 32'd0,         32'd299,       8'h2B,  8'h06};
    tab[4] = '{"param_b", 1, 24'h0,      -1, 0,  -1,    0, 100, 32'd57602,     32'd57701,     8'h63,  8'h00};

    repeat (3) @(negedge clk);
    check("rst_addr_a",  bus_a.address, 32'd0);
    check("rst_pixel_a", 32'(bus_a.pixel), 32'd0);
    check("rst_valid_a", 32'(bus_a.pixel_valid), 32'd0);
    check("rst_wb_a",    32'(bus_a.wboolean), 32'd0);
    check("rst_busy_a",  32'(busy_a), 32'd0);
    check("rst_done_a",  32'(done_a), 32'd0);
    check("rst_addr_b",  bus_b.address, 32'd0);
    check("rst_busy_b",  32'(busy_b), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(tab[i]);

    // Reset in the middle of a frame on A, while word 100 is being issued.
    sel = 1'b0;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
      if (busy_a && bus_a.address == 32'd100) found = 1;
      else @(negedge clk);
    end
    check("mid_reach_word100", 32'(found), 32'd1);
    check("mid_pixel_before", 32'(bus_a.pixel), 32'h63);
    #2 rst = 1'b0;
    #1;
    check("mid_addr",  bus_a.address, 32'd0);
    check("mid_pixel", 32'(bus_a.pixel), 32'd0);
    check("mid_valid", 32'(bus_a.pixel_valid), 32'd0);
    check("mid_busy",  32'(busy_a), 32'd0);
    check("mid_done",  32'(done_a), 32'd0);
    check("mid_wb",    32'(bus_a.wboolean), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_no_done", 32'(done_a), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_idle_after_release", 32'(busy_a), 32'd0);
    run_frame(tab[0]);

    check("wboolean_never_high", 32'(wb_seen), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
